// File: rtl/food_seller_pkg.sv
// Shared types, default constants and saturating helpers for the multi-item vending controller.
package food_seller_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_e;

    localparam int NUM_ITEMS_DEF     = 8;
    localparam int MONEY_W_DEF       = 8;
    localparam int COIN_W_DEF        = 3;
    localparam int STOCK_W_DEF       = 4;
    localparam int INIT_STOCK_DEF    = 3;
    localparam int PRICE_DEFAULT_DEF = 5;

    function automatic int unsigned sat_add(int unsigned a, int unsigned b, int unsigned max_v);
        int unsigned s;
        s = a + b;
        return (s > max_v) ? max_v : s;
    endfunction

    function automatic int unsigned sat_sub(int unsigned a, int unsigned b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

endpackage

// File: rtl/food_stock_table.sv
// Per-item stock and price storage with a merged saturating restock/decrement update.
module food_stock_table
    import food_seller_pkg::*;
#(
    parameter int NUM_ITEMS     = NUM_ITEMS_DEF,
    parameter int MONEY_W       = MONEY_W_DEF,
    parameter int STOCK_W       = STOCK_W_DEF,
    parameter int INIT_STOCK    = INIT_STOCK_DEF,
    parameter int PRICE_DEFAULT = PRICE_DEFAULT_DEF,
    parameter int ITEM_W        = $clog2(NUM_ITEMS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dec_valid,
    input  logic [ITEM_W-1:0]    dec_item,
    input  logic                 restock_valid,
    input  logic [ITEM_W-1:0]    restock_item,
    input  logic [STOCK_W-1:0]   restock_count,
    input  logic                 price_we,
    input  logic [ITEM_W-1:0]    price_item,
    input  logic [MONEY_W-1:0]   price_value,
    input  logic [ITEM_W-1:0]    rd_item,
    output logic                 rd_sold_out,
    output logic [MONEY_W-1:0]   rd_price,
    output logic [NUM_ITEMS-1:0] available
);

    localparam int unsigned STOCK_MAX = (2 ** STOCK_W) - 1;

    logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
    logic [STOCK_W-1:0] stock_d [NUM_ITEMS];
    logic [MONEY_W-1:0] price_q [NUM_ITEMS];
    logic [MONEY_W-1:0] price_d [NUM_ITEMS];
    logic               rd_in_range;

    // Vend decrement is applied before the restock add so a full slot stays full.
    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            stock_d[i] = STOCK_W'(sat_add(
                sat_sub(32'(stock_q[i]),
                        (dec_valid && dec_item == ITEM_W'(i)) ? 32'd1 : 32'd0),
                (restock_valid && restock_item == ITEM_W'(i)) ? 32'(restock_count) : 32'd0,
                STOCK_MAX));
            price_d[i] = (price_we && price_item == ITEM_W'(i)) ? price_value : price_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock_q[i] <= STOCK_W'(INIT_STOCK);
                price_q[i] <= MONEY_W'(PRICE_DEFAULT);
            end
        end else begin
            stock_q <= stock_d;
            price_q <= price_d;
        end
    end

    always_comb begin
        rd_in_range = int'(rd_item) < NUM_ITEMS;
        rd_sold_out = 1'b1;
        rd_price    = '0;
        if (rd_in_range) begin
            rd_sold_out = (stock_q[rd_item] == '0);
            rd_price    = price_q[rd_item];
        end
    end

    always_comb begin
        available = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            available[i] = (stock_q[i] != '0);
        end
    end

endmodule

// File: rtl/food_seller_multi.sv
// Multi-item vending controller: coin credit accumulation, selection, vend and change return.
module food_seller_multi
    import food_seller_pkg::*;
#(
    parameter int NUM_ITEMS     = NUM_ITEMS_DEF,
    parameter int MONEY_W       = MONEY_W_DEF,
    parameter int COIN_W        = COIN_W_DEF,
    parameter int STOCK_W       = STOCK_W_DEF,
    parameter int INIT_STOCK    = INIT_STOCK_DEF,
    parameter int PRICE_DEFAULT = PRICE_DEFAULT_DEF,
    parameter int ITEM_W        = $clog2(NUM_ITEMS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 coin_valid,
    input  logic [COIN_W-1:0]    coin_value,
    input  logic                 sel_valid,
    input  logic [ITEM_W-1:0]    sel_item,
    input  logic                 cancel,
    input  logic                 restock_valid,
    input  logic [ITEM_W-1:0]    restock_item,
    input  logic [STOCK_W-1:0]   restock_count,
    input  logic                 price_we,
    input  logic [ITEM_W-1:0]    price_item,
    input  logic [MONEY_W-1:0]   price_value,
    output logic                 vend_valid,
    output logic [ITEM_W-1:0]    vend_item,
    output logic                 change_valid,
    output logic [MONEY_W-1:0]   change_amount,
    output logic [MONEY_W-1:0]   credit,
    output logic [NUM_ITEMS-1:0] available,
    output logic                 coin_reject,
    output logic                 err_sold_out,
    output logic                 err_insufficient,
    output logic                 busy
);

    localparam int unsigned MONEY_MAX = (2 ** MONEY_W) - 1;

    state_e              state_q, state_d;
    logic [MONEY_W-1:0]  credit_q, credit_d;
    logic [MONEY_W-1:0]  price_lat_q, price_lat_d;
    logic [ITEM_W-1:0]   vend_item_q, vend_item_d;
    logic [MONEY_W-1:0]  change_amount_q, change_amount_d;
    logic                vend_valid_q, vend_valid_d;
    logic                change_valid_q, change_valid_d;
    logic                coin_reject_q, coin_reject_d;
    logic                err_sold_out_q, err_sold_out_d;
    logic                err_insufficient_q, err_insufficient_d;

    logic                dec_valid;
    logic                price_we_ok;
    logic                sel_sold_out;
    logic [MONEY_W-1:0]  sel_price;
    int unsigned         coin_sum;
    int unsigned         remain;

    food_stock_table #(
        .NUM_ITEMS     (NUM_ITEMS),
        .MONEY_W       (MONEY_W),
        .STOCK_W       (STOCK_W),
        .INIT_STOCK    (INIT_STOCK),
        .PRICE_DEFAULT (PRICE_DEFAULT),
        .ITEM_W        (ITEM_W)
    ) u_stock (
        .clk           (clk),
        .rst           (rst),
        .dec_valid     (dec_valid),
        .dec_item      (vend_item_q),
        .restock_valid (restock_valid),
        .restock_item  (restock_item),
        .restock_count (restock_count),
        .price_we      (price_we_ok),
        .price_item    (price_item),
        .price_value   (price_value),
        .rd_item       (sel_item),
        .rd_sold_out   (sel_sold_out),
        .rd_price      (sel_price),
        .available     (available)
    );

    always_comb begin
        state_d            = state_q;
        credit_d           = credit_q;
        price_lat_d        = price_lat_q;
        vend_item_d        = vend_item_q;
        change_amount_d    = change_amount_q;
        vend_valid_d       = 1'b0;
        change_valid_d     = 1'b0;
        coin_reject_d      = 1'b0;
        err_sold_out_d     = 1'b0;
        err_insufficient_d = 1'b0;
        dec_valid          = 1'b0;
        price_we_ok        = price_we && (state_q == IDLE);
        coin_sum           = 32'(credit_q) + 32'(coin_value);
        remain             = sat_sub(32'(credit_q), 32'(price_lat_q));

        unique case (state_q)
            IDLE, CREDIT: begin
                // Cancel only counts as an event once there is credit to refund.
                if (cancel && state_q == CREDIT) begin
                    coin_reject_d   = coin_valid;
                    state_d         = CHANGE;
                    change_valid_d  = (credit_q != '0);
                    change_amount_d = credit_q;
                end else if (sel_valid) begin
                    coin_reject_d = coin_valid;
                    if (sel_sold_out) begin
                        err_sold_out_d = 1'b1;
                    end else if (credit_q < sel_price) begin
                        err_insufficient_d = 1'b1;
                    end else begin
                        state_d      = VEND;
                        vend_valid_d = 1'b1;
                        vend_item_d  = sel_item;
                        price_lat_d  = sel_price;
                    end
                end else if (coin_valid) begin
                    if (coin_sum > MONEY_MAX) begin
                        coin_reject_d = 1'b1;
                    end else begin
                        credit_d = MONEY_W'(coin_sum);
                        if (coin_sum != 0) state_d = CREDIT;
                    end
                end
            end
            VEND: begin
                coin_reject_d = coin_valid;
                dec_valid     = 1'b1;
                credit_d      = MONEY_W'(remain);
                state_d       = CHANGE;
                if (remain != 0) begin
                    change_valid_d  = 1'b1;
                    change_amount_d = MONEY_W'(remain);
                end
            end
            CHANGE: begin
                coin_reject_d = coin_valid;
                credit_d      = '0;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= IDLE;
            credit_q           <= '0;
            price_lat_q        <= '0;
            vend_item_q        <= '0;
            change_amount_q    <= '0;
            vend_valid_q       <= 1'b0;
            change_valid_q     <= 1'b0;
            coin_reject_q      <= 1'b0;
            err_sold_out_q     <= 1'b0;
            err_insufficient_q <= 1'b0;
        end else begin
            state_q            <= state_d;
            credit_q           <= credit_d;
            price_lat_q        <= price_lat_d;
            vend_item_q        <= vend_item_d;
            change_amount_q    <= change_amount_d;
            vend_valid_q       <= vend_valid_d;
            change_valid_q     <= change_valid_d;
            coin_reject_q      <= coin_reject_d;
            err_sold_out_q     <= err_sold_out_d;
            err_insufficient_q <= err_insufficient_d;
        end
    end

    assign vend_valid       = vend_valid_q;
    assign vend_item        = vend_item_q;
    assign change_valid     = change_valid_q;
    assign change_amount    = change_amount_q;
    assign credit           = credit_q;
    assign coin_reject      = coin_reject_q;
    assign err_sold_out     = err_sold_out_q;
    assign err_insufficient = err_insufficient_q;
    assign busy             = (state_q == VEND) || (state_q == CHANGE);

endmodule
